serial_to_parallel: RTL and testbench

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/s2p_pkg.sv | 14 +
 rtl/s2p_bit_counter.sv | 37 +++
 rtl/serial_to_parallel.sv | 139 +++++++++++++
 tb/tb_serial_to_parallel.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the serial_to_parallel block.
//   S2P_WIDTH_DEF : default data word width.
//   s2p_state_e   : word-assembly FSM states (IDLE = no bits held,
//                   SHIFT = partial word in progress).
package s2p_pkg;

  localparam int S2P_WIDTH_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_e;

endpackage

// File: rtl/s2p_bit_counter.sv
// s2p_bit_counter: bit-position counter for word assembly.
//   clock, reset : clock / async active-low reset
//   clr_i        : synchronous clear (wins over inc_i)
//   inc_i        : count one received bit
//   count_o      : bits held so far (0..TERM-1)
//   last_o       : this increment is the TERM-th bit; counter wraps to 0
module s2p_bit_counter #(
  parameter int TERM = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    inc_i,
  output logic [$clog2(TERM)-1:0] count_o,
  output logic                    last_o
);

  localparam int CW = $clog2(TERM);

  logic [CW-1:0] count_q, count_d;

  assign last_o  = inc_i && !clr_i && (count_q == CW'(TERM - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (last_o) count_d = '0;
    else if (inc_i)  count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/serial_to_parallel.sv
// serial_to_parallel: assembles serial bits into WIDTH-bit words.
//   clock, reset : clock / async active-low reset
//   ShiftEn      : SerialIn carries a valid bit this cycle
//   SerialIn     : serial data bit
//   RotateRight  : 1 = LSB first, 0 = MSB first (sampled on a word's first bit)
//   Clear        : drop partial word and Overrun (output buffer kept)
//   Read         : consumer takes Data_OUT this cycle
//   Data_OUT     : last completed word
//   Valid        : Data_OUT holds an unread word
//   Busy         : partial word in progress
//   Overrun      : sticky, a completed word was dropped
//   ParityErr    : (SERIAL_TO_PARALLEL_PARITY_EN only) delivered word failed
//                  even parity; each word then carries one trailing parity bit
module serial_to_parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ShiftEn,
  input  logic             SerialIn,
  input  logic             RotateRight,
  input  logic             Clear,
  input  logic             Read,
  output logic [WIDTH-1:0] Data_OUT,
  output logic             Valid,
  output logic             Busy,
  output logic             Overrun
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  ,
  output logic             ParityErr
`endif
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(NBITS);

  s2p_state_e     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, data_q, data_d, shifted, word;
  logic           order_q, order_d, valid_q, valid_d, ovr_q, ovr_d;
  logic           perr_q, perr_d, bad_par, order_eff, shift_go, last;
  logic [CW-1:0]  count;

  assign shift_go = ShiftEn && !Clear;

  s2p_bit_counter #(.TERM(NBITS)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (Clear),
    .inc_i   (shift_go),
    .count_o (count),
    .last_o  (last)
  );

  // First bit of a word uses the live RotateRight; later bits the latched one.
  assign order_eff = (state_q == IDLE) ? RotateRight : order_q;
  assign shifted   = order_eff ? {SerialIn, sreg_q[WIDTH-1:1]}
                               : {sreg_q[WIDTH-2:0], SerialIn};

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  // The final bit is parity: data is already complete in sreg_q.
  assign word    = sreg_q;
  assign bad_par = ^{sreg_q, SerialIn};
`else
  assign word    = shifted;
  assign bad_par = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    order_d = order_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;

    if (shift_go) begin
      if (!(last && NBITS != WIDTH)) sreg_d = shifted;
      if (state_q == IDLE) begin
        order_d = RotateRight;
        state_d = SHIFT;
      end
      if (last) state_d = IDLE;
    end

    if (Clear) begin
      state_d = IDLE;
      ovr_d   = 1'b0;
    end

    // Completion: a Read in the same cycle frees the buffer for the new word.
    if (last) begin
      if (!valid_q || Read) begin
        data_d  = word;
        valid_d = 1'b1;
        perr_d  = bad_par;
      end else begin
        ovr_d   = 1'b1;
      end
    end else if (Read) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      order_q <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      order_q <= order_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign Data_OUT = data_q;
  assign Valid    = valid_q;
  assign Busy     = (count != '0);
  assign Overrun  = ovr_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

  localparam int W = 8;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int NB = W + 1;
  logic ParityErr;
`else
  localparam int NB = W;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ShiftEn = 1'b0, SerialIn = 1'b0, RotateRight = 1'b1, Clear = 1'b0, Read = 1'b0;
  logic [W-1:0] Data_OUT;
  logic Valid, Busy, Overrun;

  always #5 clock = ~clock;

  serial_to_parallel #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ShiftEn     (ShiftEn),
    .SerialIn    (SerialIn),
    .RotateRight (RotateRight),
    .Clear       (Clear),
    .Read        (Read),
    .Data_OUT    (Data_OUT),
    .Valid       (Valid),
    .Busy        (Busy),
    .Overrun     (Overrun)
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    ,
    .ParityErr   (ParityErr)
`endif
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference model: bits of the word in arrival order, plus the output buffer.
  bit           bq[$];
  bit           m_order = 1'b1;
  logic [W-1:0] m_data  = '0;
  bit           m_valid = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    m_order = 1'b1;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic model_step(bit sh, bit sb, bit rr, bit clr, bit rd);
    bit           done = 1'b0;
    logic [W-1:0] w = '0;
    int           ones = 0;
    if (clr) begin
      bq.delete();
      m_ovr = 1'b0;
    end else if (sh) begin
      if (bq.size() == 0) m_order = rr;
      bq.push_back(sb);
      if (bq.size() == NB) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          if (m_order) w[i] = bq[i];
          else         w[W-1-i] = bq[i];
        end
        for (int i = 0; i < NB; i++) ones += int'(bq[i]);
        if (!m_valid || rd) begin
          m_data  = w;
          m_valid = 1'b1;
          m_perr  = (ones % 2) == 1;
        end else begin
          m_ovr = 1'b1;
        end
        bq.delete();
      end
    end
    if (!done && rd) m_valid = 1'b0;
  endtask

  task automatic check_all();
    chk("data",    32'(Data_OUT), 32'(m_data));
    chk("valid",   32'(Valid),    32'(m_valid));
    chk("busy",    32'(Busy),     32'(bq.size() != 0));
    chk("overrun", 32'(Overrun),  32'(m_ovr));
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    chk("parityerr", 32'(ParityErr), 32'(m_perr));
`endif
  endtask

  // One clock: drive, clock edge, advance model, sample 1ns after the edge.
  task automatic cyc(bit sh, bit sb, bit rr, bit clr, bit rd);
    ShiftEn = sh; SerialIn = sb; RotateRight = rr; Clear = clr; Read = rd;
    @(posedge clock);
    model_step(sh, sb, rr, clr, rd);
    #1;
    check_all();
  endtask

  // seq[i] is the i-th bit sent; tog3 flips RotateRight from the 4th bit on.
  task automatic send(logic [W-1:0] seq, bit rr, bit tog3, bit rd_last);
    bit r = rr;
    for (int i = 0; i < W; i++) begin
      if (tog3 && i == 3) r = ~r;
      cyc(1'b1, seq[i], r, 1'b0, rd_last && (NB == W) && (i == W - 1));
    end
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    cyc(1'b1, ^seq, r, 1'b0, rd_last);
`endif
  endtask

  task automatic read_cyc();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_data",  32'(Data_OUT), 32'h0);
    chk("rst_valid", 32'(Valid),    32'h0);
    chk("rst_busy",  32'(Busy),     32'h0);
    chk("rst_ovr",   32'(Overrun),  32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // LSB first: 1,0,1,1,0,0,1,0 -> 4D
    send(8'h4D, 1'b1, 1'b0, 1'b0);
    chk("lsb_first_data",  32'(Data_OUT), 32'h4D);
    chk("lsb_first_valid", 32'(Valid),    32'h1);
    read_cyc();
    chk("read_clears_valid", 32'(Valid), 32'h0);

    // MSB first, same bits -> B2
    send(8'h4D, 1'b0, 1'b0, 1'b0);
    chk("msb_first_data", 32'(Data_OUT), 32'hB2);
    read_cyc();

    // RotateRight toggled mid-word is ignored
    send(8'h4D, 1'b0, 1'b1, 1'b0);
    chk("midword_toggle", 32'(Data_OUT), 32'hB2);
    read_cyc();

    // Overrun: second word dropped when nobody reads
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    chk("ovr_data_kept", 32'(Data_OUT), 32'hA5);
    chk("ovr_flag",      32'(Overrun),  32'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clear_ovr",       32'(Overrun), 32'h0);
    chk("clear_keeps_vld", 32'(Valid),   32'h1);
    read_cyc();

    // Read on the completing cycle lets the new word in
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    chk("read_on_done_data", 32'(Data_OUT), 32'h3C);
    chk("read_on_done_ovr",  32'(Overrun),  32'h0);
    chk("read_on_done_vld",  32'(Valid),    32'h1);
    read_cyc();

    // Reset mid-word, then a full word of ones
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    model_reset();
    chk("async_rst_busy", 32'(Busy),  32'h0);
    chk("async_rst_vld",  32'(Valid), 32'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("after_rst_word", 32'(Data_OUT), 32'hFF);
    read_cyc();

    // Clear after 5 bits (with ShiftEn also high: Clear wins)
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clear_busy", 32'(Busy), 32'h0);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("after_clear_word", 32'(Data_OUT), 32'h5A);
    read_cyc();

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    // 01 with parity 0 is odd -> error; with parity 1 -> clean
    for (int i = 0; i < W; i++) cyc(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("par_bad",      32'(ParityErr), 32'h1);
    chk("par_bad_data", 32'(Data_OUT),  32'h01);
    read_cyc();
    for (int i = 0; i < W; i++) cyc(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("par_good", 32'(ParityErr), 32'h0);
    read_cyc();
`endif

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit sh, sb, rr, clr, rd;
      sh  = $urandom_range(0, 9) < 7;
      sb  = 1'($urandom_range(0, 1));
      rr  = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 24) == 0;
      rd  = !clr && ($urandom_range(0, 3) == 0);
      cyc(sh, sb, rr, clr, rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
